// File: rtl/branch_resolve.sv
// Two-stage branch/jump resolution unit with prediction check
// and saturating control-flow / mispredict statistics.
module branch_resolve #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic [N-1:0]     data1_i,
  input  logic [N-1:0]     data2_i,
  input  logic [N-1:0]     pc_i,
  input  logic [N-1:0]     imm_i,
  input  logic             pred_taken_i,
  input  logic [N-1:0]     pred_target_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic [N-1:0]     target_o,
  output logic [N-1:0]     redirect_pc_o,
  output logic [N-1:0]     link_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  localparam logic [N-1:0] FOUR = N'(4);

  logic         s1_valid;
  logic         s1_br;
  logic         s1_jal;
  logic         s1_jalr;
  logic [2:0]   s1_f3;
  logic [N-1:0] s1_d1;
  logic [N-1:0] s1_d2;
  logic [N-1:0] s1_pc;
  logic [N-1:0] s1_imm;
  logic         s1_pt;
  logic [N-1:0] s1_ptgt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_br    <= 1'b0;
      s1_jal   <= 1'b0;
      s1_jalr  <= 1'b0;
      s1_f3    <= '0;
      s1_d1    <= '0;
      s1_d2    <= '0;
      s1_pc    <= '0;
      s1_imm   <= '0;
      s1_pt    <= 1'b0;
      s1_ptgt  <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (!stall_i) begin
      s1_valid <= valid_i;
      s1_br    <= is_branch_i;
      s1_jal   <= is_jal_i;
      s1_jalr  <= is_jalr_i;
      s1_f3    <= funct3_i;
      s1_d1    <= data1_i;
      s1_d2    <= data2_i;
      s1_pc    <= pc_i;
      s1_imm   <= imm_i;
      s1_pt    <= pred_taken_i;
      s1_ptgt  <= pred_target_i;
    end
  end

  logic         cond;
  logic         bad_f3;
  logic         taken;
  logic         illegal;
  logic         mispred;
  logic         ctrl;
  logic [N-1:0] pc_sum;
  logic [N-1:0] jalr_sum;
  logic [N-1:0] target;
  logic [N-1:0] link;
  logic [N-1:0] redirect;

  always_comb begin
    cond   = 1'b0;
    bad_f3 = 1'b0;
    case (s1_f3)
      3'd0:    cond = (s1_d1 == s1_d2);
      3'd1:    cond = (s1_d1 != s1_d2);
      3'd4:    cond = ($signed(s1_d1) < $signed(s1_d2));
      3'd5:    cond = ($signed(s1_d1) >= $signed(s1_d2));
      3'd6:    cond = (s1_d1 < s1_d2);
      3'd7:    cond = (s1_d1 >= s1_d2);
      default: bad_f3 = 1'b1;
    endcase
  end

  assign pc_sum   = s1_pc + s1_imm;
  assign jalr_sum = s1_d1 + s1_imm;
  assign link     = s1_pc + FOUR;
  assign ctrl     = s1_br | s1_jal | s1_jalr;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    target  = pc_sum;
    unique case (1'b1)
      s1_br: begin
        illegal = bad_f3;
        taken   = cond & ~bad_f3;
      end
      s1_jal: begin
        taken = 1'b1;
      end
      s1_jalr: begin
        taken  = 1'b1;
        target = {jalr_sum[N-1:1], 1'b0};
      end
      default: begin
        taken = 1'b0;
      end
    endcase
  end

  // A correct direction with a wrong target still needs a redirect
  assign mispred  = (taken != s1_pt)
                  | (taken & s1_pt & (s1_ptgt != target));
  assign redirect = taken ? target : link;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o         <= 1'b0;
      taken_o         <= 1'b0;
      mispredict_o    <= 1'b0;
      illegal_o       <= 1'b0;
      target_o        <= '0;
      redirect_pc_o   <= '0;
      link_o          <= '0;
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else if (flush_i) begin
      valid_o      <= 1'b0;
      taken_o      <= 1'b0;
      mispredict_o <= 1'b0;
      illegal_o    <= 1'b0;
    end else if (!stall_i) begin
      valid_o       <= s1_valid;
      taken_o       <= s1_valid & taken;
      mispredict_o  <= s1_valid & mispred;
      illegal_o     <= s1_valid & illegal;
      target_o      <= target;
      redirect_pc_o <= redirect;
      link_o        <= link;
      if (s1_valid && ctrl) begin
        if (br_count_o != '1)
          br_count_o <= br_count_o + 1'b1;
        if (mispred && mispred_count_o != '1)
          mispred_count_o <= mispred_count_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter N, default 32: data, PC and immediate width.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: synchronous active-low reset, sampled on rising edge of clk_i.
REQ-005 SHALL have port valid_i, input, 1: an instruction is presented this cycle.
REQ-006 SHALL have ports is_branch_i, is_jal_i, is_jalr_i, input, 1 each: instruction class, at most one high.
REQ-007 SHALL have port funct3_i, input, 3: branch condition code (0 eq, 1 ne, 4 lt, 5 ge, 6 ltu, 7 geu).
REQ-008 SHALL have ports data1_i, data2_i, pc_i, imm_i, input, N each: rs1, rs2, instruction PC, sign-extended immediate.
REQ-009 SHALL have ports pred_taken_i, input, 1, and pred_target_i, input, N: front-end prediction.
REQ-010 SHALL have ports stall_i and flush_i, input, 1 each: pipeline hold and pipeline kill.
REQ-011 SHALL have port valid_o, output, 1: a resolved result is presented.
REQ-012 SHALL have ports taken_o, mispredict_o, illegal_o, output, 1 each: resolved direction, prediction wrong, invalid funct3.
REQ-013 SHALL have ports target_o, redirect_pc_o, link_o, output, N each: taken target, correct next PC, pc+4.
REQ-014 SHALL have ports br_count_o and mispred_count_o, output, CNT_W each: resolved control-flow count, mispredict count.

Function
REQ-015 SHALL be a two-stage pipeline: S1 registers all inputs; S2 computes the result from S1 registers and registers all outputs; latency is 2 cycles, throughput 1 per cycle.
REQ-016 SHALL capture into S1 when rst_ni=1, stall_i=0 and flush_i=0; S1 valid takes the value of valid_i.
REQ-017 SHALL hold S1 and S2 contents and both valid bits unchanged while stall_i=1 and flush_i=0.
REQ-018 SHALL clear the S1 and S2 valid bits on any cycle with flush_i=1; flush overrides stall and any valid_i that cycle.
REQ-019 SHALL treat funct3 6/7 as an unsigned compare and 4/5 as a two's-complement signed compare over the full N bits.
REQ-020 SHALL set taken to: branch: condition of funct3; jal or jalr: 1; otherwise 0.
REQ-021 SHALL compute target as pc+imm for branch and jal, and (data1+imm) with bit 0 forced to 0 for jalr; sums wrap modulo 2^N.
REQ-022 SHALL compute link_o = pc+4 modulo 2^N, and redirect_pc_o = target_o when taken, else link_o.
REQ-023 SHALL set illegal_o=1 and taken_o=0 for a branch with funct3 2 or 3; mispredict is then evaluated with taken=0.
REQ-024 SHALL set mispredict_o=1 when taken differs from pred_taken, or when both are 1 and pred_target differs from target.
REQ-025 SHALL force taken_o, mispredict_o and illegal_o to 0 whenever valid_o=0; target_o, redirect_pc_o and link_o are don't-care then.
REQ-026 SHALL increment br_count_o by 1 on each S2 load that makes valid_o=1 with any class bit set, and mispred_count_o by 1 when that result also has mispredict=1.
REQ-027 SHALL saturate both counters at 2^CNT_W-1 with no wrap to 0.
REQ-028 SHALL not count results discarded by flush_i, and SHALL not count a held result again while stall_i=1.
REQ-029 SHALL pass a non-control instruction (no class bit) through with valid_o=1 and taken_o=mispredict_o=0 when pred_taken=0; if pred_taken=1 it SHALL report mispredict_o=1 and redirect_pc_o=link_o.

Reset
REQ-030 SHALL, on a clock edge with rst_ni=0, clear both valid bits, all registered outputs and both counters to 0, overriding stall_i and flush_i.
REQ-031 SHALL discard any in-flight instruction when reset is asserted mid-operation; the first valid_o after reset release comes 2 cycles after the first accepted valid_i.

Verification
REQ-032 SHALL pass: beq, data1=data2=5, pc=0x100, imm=0x20, pred_taken=0 -> 2 cycles later valid_o=1, taken_o=1, target_o=0x120, mispredict_o=1, redirect_pc_o=0x120, counts 1/1.
REQ-033 SHALL pass: blt, data1=0xFFFFFFFF, data2=1 -> taken_o=1; same operands with bltu -> taken_o=0.
REQ-034 SHALL pass: jalr, data1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> target_o=0x1004, mispredict_o=0, link_o=pc+4.
REQ-035 SHALL pass: back-to-back branches with stall_i high 3 cycles then flush_i for 1 cycle -> outputs frozen during stall, valid_o=0 after flush, counters unchanged by both.
REQ-036 SHALL pass: CNT_W=4, 20 mispredicting branches -> both counters read 15; then rst_ni=0 for 1 cycle -> counters 0 and valid_o=0.
REQ-037 SHALL pass: branch with funct3=2, pred_taken=1 -> illegal_o=1, taken_o=0, mispredict_o=1, redirect_pc_o=pc+4.
